// File: rtl/servo_cmd_seq.sv
// Servo command sequencer: turns a (channel, pulse-width) command into one AXI4-Lite register
// write. Defining SERVO_SEQ_READBACK_EN adds a readback of the register and a compare.
module servo_cmd_seq #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ch,
  input  logic [31:0]       cmd_data,
  output logic              busy,
  output logic              done_pulse,
  output logic              err_pulse,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWaitB,
`ifdef SERVO_SEQ_READBACK_EN
    StReadA,
    StReadR,
`endif
    StFinish
  } state_e;

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              err_q, err_d;
  logic              done_pulse_q, done_pulse_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              waiting;
  logic              timeout;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    err_d        = err_q;
    done_pulse_d = 1'b0;
    err_pulse_d  = 1'b0;
    waiting      = (state_q != StIdle) && (state_q != StFinish);
    timeout      = waiting && (cnt_q == CntW'(TIMEOUT - 1));

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d    = BASE_ADDR + ADDR_W'({cmd_ch, 2'b00});
          data_d    = cmd_data;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b0;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)          state_d   = StWaitB;
      end
      StWaitB: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
`ifdef SERVO_SEQ_READBACK_EN
            state_d = StReadA;
`else
            state_d = StFinish;
`endif
          end
        end
      end
`ifdef SERVO_SEQ_READBACK_EN
      StReadA: begin
        if (m_axi_arready) state_d = StReadR;
      end
      StReadR: begin
        if (m_axi_rvalid) begin
          if ((m_axi_rresp != 2'b00) || (m_axi_rdata != data_q)) err_d = 1'b1;
          state_d = StFinish;
        end
      end
`endif
      StFinish: begin
        // Strobes are registered, so they appear in the first IDLE cycle.
        done_pulse_d = ~err_q;
        err_pulse_d  = err_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A handshake completing on the last allowed cycle wins over the timeout.
    if (timeout && (state_d == state_q)) begin
      err_d   = 1'b1;
      state_d = StFinish;
    end

    cnt_d = (waiting && (state_d == state_q)) ? cnt_q + CntW'(1) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      err_q        <= 1'b0;
      done_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      err_q        <= err_d;
      done_pulse_q <= done_pulse_d;
      err_pulse_q  <= err_pulse_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign done_pulse    = done_pulse_q;
  assign err_pulse     = err_pulse_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = (state_q == StWrite) && !aw_done_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = (state_q == StWrite) && !w_done_q;
  assign m_axi_bready  = (state_q == StWaitB);

`ifdef SERVO_SEQ_READBACK_EN
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == StReadA);
  assign m_axi_rready  = (state_q == StReadR);
`else
  assign m_axi_araddr  = '0;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;

  logic unused_rd;
  assign unused_rd = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
`endif

endmodule

// File: tb/tb_servo_cmd_seq.sv
// Bench for servo_cmd_seq: AXI4-Lite slave with per-command wait states, a vector table,
// randomized commands against a phase-latency model, and timeout / mid-transaction reset cases.
module tb_servo_cmd_seq;

  localparam int          TMO   = 1024;
  localparam int          LIMIT = 3 * TMO + 100;
  localparam logic [31:0] BASE  = 32'h4000_1000;
`ifdef SERVO_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] data;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit          b_never;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
  } cfg_t;

  typedef struct {
    cfg_t c;
    bit   err_n;
    int   lat_n;
    bit   err_r;
    int   lat_r;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, busy, done_pulse, err_pulse;
  logic [1:0]  cmd_ch;
  logic [31:0] cmd_data;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  always #5 clock = ~clock;

  servo_cmd_seq #(
    .ADDR_W   (32),
    .BASE_ADDR(BASE),
    .TIMEOUT  (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ch       (cmd_ch),
    .cmd_data     (cmd_data),
    .busy         (busy),
    .done_pulse   (done_pulse),
    .err_pulse    (err_pulse),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awprot (m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arprot (m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  // Slave: each ready rises once its valid has waited the configured number of cycles;
  // responses start counting when their request phase has completed.
  cfg_t        cur;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit          aw_seen, w_seen, b_pend, r_pend;
  int          n_aw, n_w, n_ar, n_viol, viol_now;
  logic [31:0] cap_awaddr, cap_araddr, cap_wdata, prev_awaddr, prev_araddr, prev_wdata;
  logic [2:0]  cap_awprot, cap_arprot;
  logic [3:0]  cap_wstrb;
  logic        prev_awv, prev_awhs, prev_wv, prev_whs, prev_arv, prev_arhs;
  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= cur.aw_dly);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt >= cur.w_dly);
  assign m_axi_arready = m_axi_arvalid && (ar_cnt >= cur.ar_dly);
  assign m_axi_bvalid  = b_pend && (b_cnt >= cur.b_dly);
  assign m_axi_bresp   = m_axi_bvalid ? cur.bresp : 2'b00;
  assign m_axi_rvalid  = r_pend && (r_cnt >= cur.r_dly);
  assign m_axi_rresp   = m_axi_rvalid ? cur.rresp : 2'b00;
  assign m_axi_rdata   = m_axi_rvalid ? cur.rdata : 32'h0;
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign b_hs  = m_axi_bvalid && m_axi_bready;
  assign r_hs  = m_axi_rvalid && m_axi_rready;

  always_comb begin
    viol_now = 0;
    if (prev_awv && !prev_awhs && (!m_axi_awvalid || m_axi_awaddr != prev_awaddr))
      viol_now = viol_now + 1;
    if (prev_wv && !prev_whs && (!m_axi_wvalid || m_axi_wdata != prev_wdata))
      viol_now = viol_now + 1;
    if (prev_arv && !prev_arhs && (!m_axi_arvalid || m_axi_araddr != prev_araddr))
      viol_now = viol_now + 1;
    if ((prev_awhs && m_axi_awvalid) || (prev_whs && m_axi_wvalid) || (prev_arhs && m_axi_arvalid))
      viol_now = viol_now + 1;
    if (m_axi_awvalid && m_axi_awprot != 3'b000) viol_now = viol_now + 1;
    if (m_axi_wvalid && m_axi_wstrb != 4'hF)     viol_now = viol_now + 1;
    if (m_axi_arvalid && m_axi_arprot != 3'b000) viol_now = viol_now + 1;
  end

  always @(posedge clock) begin
    if (reset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      prev_awv <= 1'b0; prev_awhs <= 1'b0; prev_wv <= 1'b0; prev_whs <= 1'b0;
      prev_arv <= 1'b0; prev_arhs <= 1'b0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      if (aw_hs) begin n_aw <= n_aw + 1; cap_awaddr <= m_axi_awaddr; cap_awprot <= m_axi_awprot; end
      if (w_hs)  begin n_w <= n_w + 1; cap_wdata <= m_axi_wdata; cap_wstrb <= m_axi_wstrb; end
      if (ar_hs) begin n_ar <= n_ar + 1; cap_araddr <= m_axi_araddr; cap_arprot <= m_axi_arprot; end
      if (b_pend) begin
        if (b_hs) b_pend <= 1'b0;
        else      b_cnt <= b_cnt + 1;
      end else if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
        b_pend <= !cur.b_never; b_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        if (aw_hs) aw_seen <= 1'b1;
        if (w_hs)  w_seen <= 1'b1;
      end
      if (r_pend) begin
        if (r_hs) r_pend <= 1'b0;
        else      r_cnt <= r_cnt + 1;
      end else if (ar_hs) begin
        r_pend <= 1'b1; r_cnt <= 0;
      end
      n_viol      <= n_viol + viol_now;
      prev_awv    <= m_axi_awvalid; prev_awhs <= aw_hs; prev_awaddr <= m_axi_awaddr;
      prev_wv     <= m_axi_wvalid;  prev_whs  <= w_hs;  prev_wdata  <= m_axi_wdata;
      prev_arv    <= m_axi_arvalid; prev_arhs <= ar_hs; prev_araddr <= m_axi_araddr;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cfg_t mk(input logic [1:0] ch, input logic [31:0] data, input int aw,
                              input int w, input int b, input logic [1:0] bresp, input int ar,
                              input int r, input logic [31:0] rdata, input logic [1:0] rresp);
    cfg_t c;
    c.ch = ch; c.data = data; c.aw_dly = aw; c.w_dly = w; c.b_dly = b; c.ar_dly = ar;
    c.r_dly = r; c.b_never = 1'b0; c.bresp = bresp; c.rresp = rresp; c.rdata = rdata;
    return c;
  endfunction

  // Each handshake phase with delay d lasts d+1 cycles (capped at TMO, which is an error);
  // then one FINISH cycle, then the strobe cycle.
  function automatic void model(input cfg_t c, output bit e, output int lat, output int bcyc,
                                output int ars);
    int wr, bp;
    e = 1'b0; ars = 0; bcyc = 0; lat = 2;
    wr = ((c.aw_dly > c.w_dly) ? c.aw_dly : c.w_dly) + 1;
    if (wr > TMO) begin lat += TMO; e = 1'b1; return; end
    lat += wr;
    bp = c.b_never ? TMO + 1 : c.b_dly + 1;
    if (bp > TMO) begin lat += TMO; bcyc = TMO; e = 1'b1; return; end
    lat += bp; bcyc = bp;
    if (c.bresp != 2'b00) begin e = 1'b1; return; end
    if (!RB) return;
    ars = 1;
    lat += c.ar_dly + 1 + c.r_dly + 1;
    e = (c.rresp != 2'b00) || (c.rdata != c.data);
  endfunction

  task automatic exec(input string tag, input cfg_t c, input bit exp_err, input int exp_lat,
                      input int exp_bcyc, input int exp_ars);
    int lat, bcyc, aw0, w0, ar0, v0;
    logic [31:0] exp_addr;
    exp_addr = BASE + {28'h0, c.ch, 2'b00};
    @(negedge clock);
    cur = c;
    aw0 = n_aw; w0 = n_w; ar0 = n_ar; v0 = n_viol;
    cmd_valid = 1'b1; cmd_ch = c.ch; cmd_data = c.data;
    check({tag, ".cmd_ready"}, cmd_ready, 1);
    lat = 0; bcyc = 0;
    do begin
      @(negedge clock);
      lat++;
      cmd_valid = 1'b0;
      if (m_axi_bready) bcyc++;
    end while (!(done_pulse || err_pulse) && lat < LIMIT);
    if (!(done_pulse || err_pulse)) begin
      n_checks++; n_fail++;
      $display("FAIL %s.strobe: got none after %0d cycles, expected one", tag, lat);
      reset = 1'b1; @(negedge clock); reset = 1'b0;
      return;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".err"}, err_pulse, exp_err);
    check({tag, ".one_strobe"}, done_pulse ^ err_pulse, 1);
    check({tag, ".n_aw"}, n_aw - aw0, 1);
    check({tag, ".n_w"}, n_w - w0, 1);
    check({tag, ".awaddr"}, cap_awaddr, exp_addr);
    check({tag, ".wdata"}, cap_wdata, c.data);
    check({tag, ".wstrb_prot"}, {cap_wstrb, cap_awprot}, {4'hF, 3'b000});
    check({tag, ".bready_cycles"}, bcyc, exp_bcyc);
    check({tag, ".n_ar"}, n_ar - ar0, exp_ars);
    if (exp_ars != 0) check({tag, ".araddr"}, {cap_arprot, cap_araddr}, {3'b000, exp_addr});
    check({tag, ".protocol"}, n_viol - v0, 0);
    @(negedge clock);
    check({tag, ".strobes_after"}, {done_pulse, err_pulse}, 2'b00);
    check({tag, ".ready_after"}, {cmd_ready, busy, m_axi_bready}, 3'b100);
  endtask

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_t c;
    bit   e;
    int   l, b, a;

    //             ch     data          aw w  b  bresp  ar r  rdata         rresp
    vecs[0] = '{mk(2'd2, 32'h0000_05DC, 0, 0, 0, 2'b00, 0, 0, 32'h0000_05DC, 2'b00), 0, 4, 0, 6};
    vecs[1] = '{mk(2'd1, 32'h0000_0123, 3, 0, 0, 2'b00, 0, 0, 32'h0000_0123, 2'b00), 0, 7, 0, 9};
    vecs[2] = '{mk(2'd3, 32'h0000_0ABC, 0, 3, 0, 2'b00, 0, 0, 32'h0000_0ABC, 2'b00), 0, 7, 0, 9};
    vecs[3] = '{mk(2'd0, 32'h0000_0777, 0, 0, 0, 2'b10, 0, 0, 32'h0000_0777, 2'b00), 1, 4, 1, 4};
    vecs[4] = '{mk(2'd2, 32'h0000_05DC, 0, 0, 0, 2'b00, 0, 0, 32'h0000_05DB, 2'b00), 0, 4, 1, 6};
    vecs[5] = '{mk(2'd1, 32'h0000_0055, 2, 2, 1, 2'b00, 1, 2, 32'h0000_0055, 2'b00), 0, 7, 0, 12};
    vecs[6] = '{mk(2'd0, 32'h0000_0099, 0, 0, 0, 2'b00, 0, 0, 32'h0000_0099, 2'b10), 0, 4, 1, 6};
    vecs[7] = '{mk(2'd3, 32'hFFFF_FFFF, 0, 0, 3, 2'b00, 0, 0, 32'hFFFF_FFFF, 2'b00), 0, 7, 0, 9};
    vecs[8] = '{mk(2'd1, 32'h0000_0000, 1, 0, 0, 2'b11, 0, 0, 32'h0000_0000, 2'b00), 1, 5, 1, 5};

    reset = 1'b1; cmd_valid = 1'b0; cmd_ch = 2'd0; cmd_data = 32'h0;
    n_aw = 0; n_w = 0; n_ar = 0; n_viol = 0;
    cur = mk(2'd0, 32'h0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset.ready_busy", {cmd_ready, busy}, 2'b10);
    check("reset.valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                           m_axi_rready, done_pulse, err_pulse}, 7'b0);
    check("reset.addr_data", {m_axi_awaddr, m_axi_wdata, m_axi_araddr}, 96'h0);

    for (int i = 0; i < 9; i++) begin
      model(vecs[i].c, e, l, b, a);
      exec($sformatf("vec%0d", i), vecs[i].c, RB ? vecs[i].err_r : vecs[i].err_n,
           RB ? vecs[i].lat_r : vecs[i].lat_n, b, a);
    end

    for (int i = 0; i < 30; i++) begin
      c = mk(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 4), ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00,
             $urandom_range(0, 4), $urandom_range(0, 4), 32'h0,
             ($urandom_range(0, 5) == 0) ? 2'b11 : 2'b00);
      c.rdata = ($urandom_range(0, 3) == 0) ? c.data ^ (32'h1 << $urandom_range(0, 31)) : c.data;
      model(c, e, l, b, a);
      exec($sformatf("rand%0d", i), c, e, l, b, a);
    end

    // B response never arrives: WAIT_B must give up after exactly TMO cycles.
    c = mk(2'd1, 32'h0000_0321, 0, 0, 0, 2'b00, 0, 0, 32'h0000_0321, 2'b00);
    c.b_never = 1'b1;
    model(c, e, l, b, a);
    exec("timeout", c, e, l, b, a);

    // Reset while the write address is still outstanding.
    cur = mk(2'd3, 32'hDEAD_BEEF, 6, 6, 0, 2'b00, 0, 0, 32'hDEAD_BEEF, 2'b00);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_ch = 2'd3; cmd_data = 32'hDEAD_BEEF;
    check("rst_mid.cmd_ready", cmd_ready, 1);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("rst_mid.in_flight", {m_axi_awvalid, m_axi_wvalid, busy}, 3'b111);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid.valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                             m_axi_rready, busy, done_pulse, err_pulse}, 8'b0);
    check("rst_mid.addr_data", {m_axi_awaddr, m_axi_wdata, m_axi_araddr}, 96'h0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid.ready_after", {cmd_ready, busy}, 2'b10);
    c = mk(2'd2, 32'h0000_05DC, 0, 0, 0, 2'b00, 0, 0, 32'h0000_05DC, 2'b00);
    exec("post_rst", c, 1'b0, RB ? 6 : 4, 1, RB ? 1 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_cmd_seq.md
SERVO_CMD_SEQ -- requirements
Module: servo_cmd_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the AXI4-Lite address width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the servo register bank base; channel n maps to BASE_ADDR + 4*n.
REQ-003 SHALL have parameter TIMEOUT, default 1024, the maximum cycles to wait for any AXI handshake.
REQ-004 SHALL have port clock, in, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, in, 1: synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid, in, 1: command offered.
REQ-007 SHALL have port cmd_ready, out, 1: command accepted when cmd_valid & cmd_ready.
REQ-008 SHALL have port cmd_ch, in, 2: servo channel 0..3.
REQ-009 SHALL have port cmd_data, in, 32: pulse-width register value.
REQ-010 SHALL have port busy, out, 1: a command is in progress.
REQ-011 SHALL have ports done_pulse and err_pulse, out, 1 each: one-cycle completion and failure strobes.
REQ-012 SHALL have ports m_axi_awaddr (out, ADDR_W), m_axi_awprot (out, 3), m_axi_awvalid (out, 1), m_axi_awready (in, 1): AXI4-Lite write address channel.
REQ-013 SHALL have ports m_axi_wdata (out, 32), m_axi_wstrb (out, 4), m_axi_wvalid (out, 1), m_axi_wready (in, 1): write data channel.
REQ-014 SHALL have ports m_axi_bresp (in, 2), m_axi_bvalid (in, 1), m_axi_bready (out, 1): write response channel.
REQ-015 SHALL have ports m_axi_araddr (out, ADDR_W), m_axi_arprot (out, 3), m_axi_arvalid (out, 1), m_axi_arready (in, 1), m_axi_rdata (in, 32), m_axi_rresp (in, 2), m_axi_rvalid (in, 1), m_axi_rready (out, 1): read channels.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, WAIT_B, READ_A, READ_R, FINISH.
REQ-017 SHALL assert cmd_ready only in IDLE; on acceptance, SHALL register the address (BASE_ADDR + 4*cmd_ch) and cmd_data and go to WRITE on the next cycle.
REQ-018 In WRITE, SHALL assert awvalid and wvalid together, deassert each independently on its own handshake, and go to WAIT_B once both have completed, in either order or in the same cycle.
REQ-019 SHALL hold awaddr, wdata, wstrb=4'hF and awprot=3'b000 stable while the corresponding valid is high.
REQ-020 In WAIT_B, SHALL assert bready; on bvalid with bresp=2'b00 SHALL go to READ_A when readback is compiled in, otherwise to FINISH; on bresp!=0 SHALL flag an error and go to FINISH.
REQ-021 In READ_A, SHALL assert arvalid with araddr equal to awaddr and arprot=3'b000; on arready SHALL go to READ_R.
REQ-022 In READ_R, SHALL assert rready; on rvalid SHALL flag an error if rresp!=0 or rdata!=registered data, then go to FINISH.
REQ-023 In FINISH, SHALL pulse exactly one of done_pulse or err_pulse for one cycle and return to IDLE; a new command is accepted no earlier than the following cycle.
REQ-024 SHALL count cycles spent in each waiting state, clearing the count on state change; reaching TIMEOUT SHALL flag an error, drop all valid and ready outputs, and go to FINISH.
REQ-025 SHALL assert busy in every state except IDLE.
REQ-026 Minimum latency from cmd acceptance to done_pulse with zero-wait slave: 4 cycles without readback, 6 with.

Reset
REQ-027 Reset SHALL force IDLE and clear every valid, ready, busy, pulse, counter and registered address/data to 0, including mid-transaction; cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 Macro SERVO_SEQ_READBACK_EN defined: WAIT_B proceeds to READ_A and the readback compare of REQ-021/REQ-022 is performed.
REQ-029 SERVO_SEQ_READBACK_EN undefined: READ_A and READ_R are absent, arvalid and rready are tied to 0, and araddr and arprot are tied to 0.

Verification
REQ-030 cmd ch=2, data=0x5DC; slave has zero wait states -> awaddr=BASE+0x8, wdata=0x5DC, done_pulse after 4 cycles (6 with readback), err_pulse=0.
REQ-031 awready delayed 3 cycles, wready immediate, then reversed order -> each valid drops on its own handshake and both cases complete with done_pulse.
REQ-032 bresp=2'b10 -> err_pulse one cycle, no read issued, cmd_ready=1 the following cycle.
REQ-033 Readback enabled, rdata=0x5DB versus written 0x5DC -> err_pulse; rdata=0x5DC -> done_pulse.
REQ-034 bvalid never asserted -> err_pulse at TIMEOUT=1024 cycles after entering WAIT_B, bready low afterwards.
REQ-035 reset asserted while awvalid=1 -> next cycle all outputs at reset values, busy=0, and a new command is accepted normally.
